fb_mem_arbiter: RTL and testbench

//  Shares the single frame/depth-buffer Avalon-MM master among NREQ pipeline requesters
//  (0: depth-read fetch, 1: colour write from z-test, 2: depth write-back).

---
 rtl/fb_mem_pkg.sv | 25 ++
 rtl/fb_mem_arbiter_if.sv | 37 +++
 rtl/fb_rd_tag_fifo.sv | 53 +++++
 rtl/fb_mem_arbiter.sv | 88 ++++++++
 tb/tb_fb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_mem_pkg.sv
// Shared types and sizing for the frame/depth-buffer memory arbiter.
// Widths live here so the interface, arbiter and tag FIFO always agree.
package fb_mem_pkg;
  localparam int NREQ    = 3;
  localparam int AW      = 26;
  localparam int DW      = 32;
  localparam int MAX_OUT = 8;
  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, ISSUE} arb_state_e;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
  } avl_cmd_t;

  function automatic logic [NREQ-1:0] idx_onehot(req_idx_t i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Requester-side and Avalon-MM master-side bus of the arbiter.
// master = the arbiter itself; slave = requesters plus memory.
interface fb_mem_arbiter_if;
  import fb_mem_pkg::*;

  logic [NREQ*AW-1:0] req_address;
  logic [NREQ-1:0]    req_read;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*4-1:0]  req_byteenable;
  logic [NREQ*DW-1:0] req_writedata;
  logic [NREQ-1:0]    req_waitrequest;
  logic [DW-1:0]      req_readdata;
  logic [NREQ-1:0]    req_readdatavalid;

  logic [AW-1:0]      master_address;
  logic               master_read;
  logic               master_write;
  logic [3:0]         master_byteenable;
  logic [DW-1:0]      master_writedata;
  logic [DW-1:0]      master_readdata;
  logic               master_readdatavalid;
  logic               master_waitrequest;

  modport master (
    input  req_address, req_read, req_write, req_byteenable, req_writedata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output master_address, master_read, master_write, master_byteenable, master_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest
  );

  modport slave (
    output req_address, req_read, req_write, req_byteenable, req_writedata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  master_address, master_read, master_write, master_byteenable, master_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest
  );
endinterface

// File: rtl/fb_rd_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read.
// Simultaneous push and pop are allowed, including when full.
module fb_rd_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/fb_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among pipeline requesters.
// One command in flight; read beats are routed back through a tag FIFO.
module fb_mem_arbiter
  import fb_mem_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  fb_mem_arbiter_if.master    bus,
  output logic                err_sticky
);
  arb_state_e      state_q;
  req_idx_t        gnt_q, rr_q, pick, tag_head;
  avl_cmd_t        cmd_q, sel;
  logic            err_q;
  logic [NREQ-1:0] elig, both;
  logic            any, accept, push, pop, tag_full, tag_empty;

  always_comb begin
    elig = bus.req_write | (bus.req_read & {NREQ{~tag_full}});
    both = bus.req_read & bus.req_write;
    any  = 1'b0;
    pick = rr_q;
    // first eligible index strictly after the RR pointer, wrapping
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && elig[(int'(rr_q) + k) % NREQ]) begin
        any  = 1'b1;
        pick = req_idx_t'((int'(rr_q) + k) % NREQ);
      end
    end
    sel.addr  = bus.req_address[int'(pick)*AW +: AW];
    sel.be    = bus.req_byteenable[int'(pick)*4 +: 4];
    sel.wdata = bus.req_writedata[int'(pick)*DW +: DW];
    sel.wr    = bus.req_write[pick];
    sel.rd    = bus.req_read[pick] & ~bus.req_write[pick];
  end

  assign accept = (state_q == ISSUE) & ~bus.master_waitrequest;
  assign push   = accept & cmd_q.rd;
  assign pop    = bus.master_readdatavalid & ~tag_empty;

  assign bus.req_waitrequest   = accept ? ~idx_onehot(gnt_q) : '1;
  assign bus.req_readdatavalid = pop ? idx_onehot(tag_head) : '0;
  assign bus.req_readdata      = bus.master_readdata;

  assign bus.master_address    = cmd_q.addr;
  assign bus.master_byteenable = cmd_q.be;
  assign bus.master_writedata  = cmd_q.wdata;
  assign bus.master_read       = cmd_q.rd;
  assign bus.master_write      = cmd_q.wr;
  assign err_sticky            = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= req_idx_t'(NREQ-1);
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((|both) || (bus.master_readdatavalid && tag_empty)) err_q <= 1'b1;
      case (state_q)
        IDLE: if (any) begin
          cmd_q   <= sel;
          gnt_q   <= pick;
          state_q <= ISSUE;
        end
        ISSUE: if (!bus.master_waitrequest) begin
          rr_q     <= gnt_q;
          cmd_q.rd <= 1'b0;
          cmd_q.wr <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fb_rd_tag_fifo #(.DEPTH(MAX_OUT), .W(IDX_W)) u_tags (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   (gnt_q),
    .pop_i   (pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench: directed requester queues, expected commands/beats queued
// up front and checked by a monitor whenever the DUT accepts or returns data.
module tb_fb_mem_arbiter;
  import fb_mem_pkg::*;

  typedef struct {
    int            gnt;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } exp_cmd_t;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
  } exp_beat_t;

  logic clock, reset;
  logic err_sticky;
  fb_mem_arbiter_if bus();

  fb_mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus), .err_sticky(err_sticky));

  int checks = 0, errors = 0, cyc = 0;
  avl_cmd_t  drv_q [NREQ][$];
  exp_cmd_t  exp_q[$];
  exp_beat_t beat_q[$];
  int        acc_log[$];
  int        pres_cyc [NREQ];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tk();
    @(posedge clock); #2;
  endtask

  task automatic issue(input int r, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] d);
    avl_cmd_t c;
    c.addr = a; c.be = be; c.wdata = d; c.rd = rd; c.wr = wr;
    drv_q[r].push_back(c);
  endtask

  task automatic expect_cmd(input int g, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [DW-1:0] d);
    exp_cmd_t e;
    e.gnt = g; e.rd = rd; e.wr = wr; e.addr = a; e.be = be; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_beat(input int w, input logic [DW-1:0] d);
    exp_beat_t b;
    b.who = w; b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge clock);
      cyc++;
    end
  endtask

  // Requesters hold their head command until they see their waitrequest low.
  task automatic driver();
    logic [NREQ-1:0]    acc, active, rd, wr;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*4-1:0]  be;
    logic [NREQ*DW-1:0] d;
    acc = '0; active = '0;
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (reset) begin
          drv_q[i].delete();
          active[i] = 1'b0;
        end else if (acc[i] && drv_q[i].size() > 0) begin
          drv_q[i].delete(0);
          active[i] = 1'b0;
        end
      end
      rd = '0; wr = '0; a = '0; be = '0; d = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (drv_q[i].size() > 0) begin
          if (!active[i]) begin
            active[i]   = 1'b1;
            pres_cyc[i] = cyc;
          end
          rd[i] = drv_q[i][0].rd;
          wr[i] = drv_q[i][0].wr;
          a[i*AW +: AW] = drv_q[i][0].addr;
          be[i*4 +: 4]  = drv_q[i][0].be;
          d[i*DW +: DW] = drv_q[i][0].wdata;
        end
      end
      bus.req_read = rd; bus.req_write = wr; bus.req_address = a;
      bus.req_byteenable = be; bus.req_writedata = d;
      @(negedge clock);
      acc = reset ? '0 : ~bus.req_waitrequest;
    end
  endtask

  task automatic monitor();
    exp_cmd_t        e;
    exp_beat_t       b;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((bus.master_read || bus.master_write) && !bus.master_waitrequest) begin
          acc_log.push_back(cyc);
          if (exp_q.size() == 0) chk("unexpected_cmd", 64'd1, 64'd0);
          else begin
            e  = exp_q.pop_front();
            oh = ~(NREQ'(1) << e.gnt);
            chk("cmd_req_waitrequest", bus.req_waitrequest, oh);
            chk("cmd_read", bus.master_read, e.rd);
            chk("cmd_write", bus.master_write, e.wr);
            chk("cmd_address", bus.master_address, e.addr);
            chk("cmd_byteenable", bus.master_byteenable, e.be);
            if (e.wr) chk("cmd_writedata", bus.master_writedata, e.wdata);
          end
        end
        if (bus.req_readdatavalid != '0) begin
          if (beat_q.size() == 0) chk("unexpected_beat", bus.req_readdatavalid, 64'd0);
          else begin
            b  = beat_q.pop_front();
            oh = NREQ'(1) << b.who;
            chk("beat_owner", bus.req_readdatavalid, oh);
            chk("beat_data", bus.req_readdata, b.data);
          end
        end
      end
    end
  endtask

  task automatic wait_acc(input int n, input int lim);
    int t = 0;
    while (acc_log.size() < n && t < lim) begin
      tk();
      t++;
    end
    chk($sformatf("accepts_reached_%0d", n), acc_log.size(), n);
  endtask

  task automatic do_reset();
    chk("pending_cmds_before_reset", exp_q.size(), 0);
    chk("pending_beats_before_reset", beat_q.size(), 0);
    reset = 1'b1;
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    tk(); tk();
    chk("rst_master_read", bus.master_read, 0);
    chk("rst_master_write", bus.master_write, 0);
    chk("rst_master_address", bus.master_address, 0);
    chk("rst_req_waitrequest", bus.req_waitrequest, 3'b111);
    chk("rst_req_readdatavalid", bus.req_readdatavalid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    reset = 1'b0;
    acc_log.delete();
    tk();
  endtask

  initial begin
    int t;
    reset = 1'b1;
    bus.master_waitrequest = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata = '0;
    fork
      cycle_counter();
      driver();
      monitor();
    join_none
    do_reset();

    // 1: one read left outstanding, then a write stalled by waitrequest, then reset
    expect_cmd(0, 1, 0, 26'h40, 4'hF, 0);
    issue(0, 1, 0, 26'h40, 4'hF, 0);
    wait_acc(1, 20);
    bus.master_waitrequest = 1'b1;
    issue(0, 0, 1, 26'h50, 4'hF, 32'hDEAD0050);
    t = 0;
    while (!bus.master_write && t < 10) begin tk(); t++; end
    chk("t1_write_on_master", bus.master_write, 1);
    tk(); tk();
    chk("t1_write_held", bus.master_write, 1);
    chk("t1_addr_held", bus.master_address, 26'h50);
    reset = 1'b1;
    tk();
    chk("t1_rst_master_write", bus.master_write, 0);
    chk("t1_rst_req_waitrequest", bus.req_waitrequest, 3'b111);
    bus.master_waitrequest = 1'b0;
    reset = 1'b0;
    tk();
    // stale beat after reset: the tag from the earlier read must be gone
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata = 32'h5A5A5A5A;
    #1;
    chk("t1_stale_beat_dropped", bus.req_readdatavalid, 0);
    tk();
    bus.master_readdatavalid = 1'b0;
    chk("t6_err_empty_fifo", err_sticky, 1);
    do_reset();

    // 2: single write from requester 1
    expect_cmd(1, 0, 1, 26'h0000123, 4'hF, 32'hFF00FF00);
    issue(1, 0, 1, 26'h0000123, 4'hF, 32'hFF00FF00);
    wait_acc(1, 20);
    chk("t2_latency", acc_log[0] - pres_cyc[1], 1);
    chk("t2_idle_write", bus.master_write, 0);
    chk("t2_idle_waitrequest", bus.req_waitrequest, 3'b111);
    do_reset();

    // 3: all three write continuously: grant 0,1,2,0,1,2 every 2 cycles
    for (int j = 0; j < 2; j++)
      for (int r = 0; r < NREQ; r++) begin
        expect_cmd(r, 0, 1, 26'h200 + 26'(r*16 + j), 4'h3, 32'hC0DE0000 + 32'(r*16 + j));
        issue(r, 0, 1, 26'h200 + 26'(r*16 + j), 4'h3, 32'hC0DE0000 + 32'(r*16 + j));
      end
    wait_acc(6, 40);
    for (int k = 1; k < 6; k++)
      if (acc_log.size() > k) chk($sformatf("t3_spacing_%0d", k), acc_log[k] - acc_log[k-1], 2);
    do_reset();

    // 4: eight reads fill the tag FIFO; ninth blocked, a write still proceeds
    for (int k = 0; k < 9; k++) issue(0, 1, 0, 26'h300 + 26'(k), 4'hF, 0);
    for (int k = 0; k < 8; k++) expect_cmd(0, 1, 0, 26'h300 + 26'(k), 4'hF, 0);
    wait_acc(8, 60);
    repeat (6) tk();
    chk("t4_read9_blocked", acc_log.size(), 8);
    chk("t4_master_read_idle", bus.master_read, 0);
    expect_cmd(2, 0, 1, 26'h3F0, 4'hF, 32'h0BADF00D);
    issue(2, 0, 1, 26'h3F0, 4'hF, 32'h0BADF00D);
    wait_acc(9, 20);
    expect_cmd(0, 1, 0, 26'h308, 4'hF, 0);
    for (int k = 0; k < 8; k++) begin
      expect_beat(0, 32'hB000 + 32'(k));
      bus.master_readdatavalid = 1'b1;
      bus.master_readdata = 32'hB000 + 32'(k);
      tk();
    end
    bus.master_readdatavalid = 1'b0;
    wait_acc(10, 20);
    expect_beat(0, 32'hB008);
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata = 32'hB008;
    tk();
    bus.master_readdatavalid = 1'b0;
    tk();
    chk("t4_no_err", err_sticky, 0);
    do_reset();

    // 5: reads 0,2,0; first beat lands in the accept cycle of the third read
    expect_cmd(0, 1, 0, 26'h400, 4'hF, 0);
    expect_cmd(2, 1, 0, 26'h410, 4'hF, 0);
    expect_cmd(0, 1, 0, 26'h404, 4'hF, 0);
    issue(0, 1, 0, 26'h400, 4'hF, 0);
    issue(0, 1, 0, 26'h404, 4'hF, 0);
    issue(2, 1, 0, 26'h410, 4'hF, 0);
    wait_acc(1, 20);
    expect_beat(0, 32'hAAAA0000);
    expect_beat(2, 32'hBBBB0002);
    repeat (3) tk();
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata = 32'hAAAA0000;
    tk();
    bus.master_readdata = 32'hBBBB0002;
    tk();
    bus.master_readdatavalid = 1'b0;
    wait_acc(3, 20);
    if (acc_log.size() >= 3) chk("t5_third_read_with_beat", acc_log[2] - acc_log[0], 4);
    expect_beat(0, 32'hCCCC0004);
    bus.master_readdatavalid = 1'b1;
    bus.master_readdata = 32'hCCCC0004;
    tk();
    bus.master_readdatavalid = 1'b0;
    tk();
    chk("t5_no_err", err_sticky, 0);
    do_reset();

    // 6: read and write together on requester 1 goes out as a write and flags an error
    expect_cmd(1, 0, 1, 26'h500, 4'hF, 32'h12345678);
    issue(1, 1, 1, 26'h500, 4'hF, 32'h12345678);
    wait_acc(1, 20);
    tk();
    chk("t6_err_rd_wr", err_sticky, 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
